t5_hart_sched: RTL and testbench
================================

Name: t5_hart_sched

Overview:
- Barrel-thread scheduler for the t5 core. Each cycle it picks one runnable hart (4 harts), presents that hart's fetch PC and hart ID, and advances the PC.
- It owns the per-hart PC file and per-hart run/busy state, and applies branch/trap redirects resolved by the ASLU at execute.
- It sits at the front of the pipeline and sequences the shared fetch/decode/ASLU datapath between harts.

Parameters:
- XLEN, 32, PC width.
- RESET_PC, 32'h0000_0000, reset PC loaded into every hart.

Ports:
- sclk  in  1  clock.
- srst  in  1  synchronous reset, active-low.
- sena  in  1  pipeline enable; all state updates are gated by sena.
- hstart  in  4  one-hot/multi-hot hart start requests.
- hstop  in  4  hart stop requests.
- hpc  in  XLEN  start PC, loaded into every hart named in hstart.
- xvld  in  1  execute retires an instruction this cycle.
- xhart  in  2  hart ID of the retiring instruction.
- xbra  in  1  retiring instruction redirects its hart (branch/jump/trap).
- xbpc  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- fvld  out  1  fpc/fhart are a valid issue slot.
- fhart  out  2  issued hart ID.
- fpc  out  XLEN  issued PC, word-aligned.
- hrun  out  4  per-hart enabled state.
- sidle  out  32  idle-slot counter (see Optional Feature).

Behaviour:
- Reset (srst=0 at sclk edge, regardless of sena):
  - fvld=0, fhart=0, fpc=RESET_PC.
  - hrun=4'b0001; all busy bits=0; all PCs=RESET_PC.
  - Round-robin pointer=3, so hart 0 is searched first.
  - sidle=0.
- sena=0: all registers hold; fvld, fhart and fpc hold; inputs are ignored.
- Runnable[h] = hrun[h] & !busy[h], evaluated on registered state. A completion clears busy in the same edge, so that hart is eligible only from the next cycle.
- Selection:
  - Search from pointer+1, wrapping modulo 4; take the first runnable hart h.
  - On the edge: fvld<=1, fhart<=h, fpc<=pc[h], pc[h]<=pc[h]+4 (mod 2^XLEN, wraps silently), busy[h]<=1, pointer<=h.
  - Issue latency is one cycle: the registered outputs reflect the selection on the following cycle.
- No runnable hart: fvld<=0; fhart and fpc hold; pointer unchanged.
- Completion (xvld=1): busy[xhart]<=0.
  - If xbra=1 also: pc[xhart]<={xbpc[XLEN-1:2],2'b00}. This overrides the +4 already applied.
  - xbra is ignored when xvld=0.
  - xvld for a non-busy hart clears nothing and is a protocol error (no assertion in RTL).
- Start/stop:
  - hstart[h] & !hrun[h]: hrun[h]<=1 and pc[h]<=hpc aligned.
  - hstart on an already-running hart: ignored, PC unchanged.
  - hstop[h]: hrun[h]<=0. An in-flight instruction still completes and its redirect still updates pc[h]; no further issue follows.
  - hstart[h] & hstop[h] in the same cycle: stop wins, and the PC is not loaded.
  - All four harts stopped: fvld stays 0 until the next hstart.
- Same-cycle interactions:
  - Completion and issue on different harts both take effect.
  - Issue and completion on the same hart cannot coincide, because the hart is busy.
  - hstop on the hart being selected this edge: the selection uses the old hrun, so it issues once, then stops.
- Reset mid-operation: busy bits clear. In-flight completions arriving after reset are protocol errors; upstream flushes the pipeline on reset.

Optional Feature:
- Macro T5_SCHED_IDLE_CNT_EN.
- Defined:
  - sidle is a 32-bit counter, incremented on each sena edge where the newly registered fvld=0.
  - It wraps from 32'hFFFF_FFFF to 0 and resets to 0.
- Undefined: sidle is tied to 32'h0 and no counter is built.

Test Plan:
1. Reset then sena=1, no starts; retire hart 0 via xvld two cycles after each issue -> fvld/fhart show hart 0 at 0x0, 0x4, 0x8… with idle (fvld=0) gaps; sidle counts those gaps when the macro is defined.
2. hstart=4'b1110, hpc=0x100 -> harts 1,2,3 load 0x100; with prompt retirements the issue order is 0,1,2,3,0… with PCs 0x0,0x100,0x100,0x100,0x4.
3. Hart 2 retires with xbra=1, xbpc=0x2003 -> hart 2's next issue has fpc=0x2000, then 0x2004.
4. hstop=4'b0100 while hart 2 is busy; later hart 2 retires with xbra=1, xbpc=0x3000 -> hart 2 is never issued again, hrun=4'b1011, pc[2]=0x3000; later hstart[2] with hpc=0x500 -> next hart-2 issue at 0x500.
5. hstart[1] and hstop[1] same cycle on a stopped hart -> hrun[1] stays 0; all harts stopped -> fvld=0 and fhart/fpc held.
6. sena=0 for 3 cycles mid-stream with xvld pulses asserted -> no state change, outputs frozen; resuming continues the round-robin from the held pointer.

Source files
------------

// File: rtl/t5_hart_sched_if.sv
// Bundle between the t5 front end and the hart scheduler: control, retirement and issue.
interface t5_hart_sched_if #(
    parameter int XLEN = 32
);
    // Both strobes are valid-only with no ready.
    // xvld qualifies xhart/xbra/xbpc on the edge where it is high and sena is high.
    // fvld qualifies fhart/fpc for the cycle the scheduler holds it high.
    logic            sena;
    logic [3:0]      hstart;
    logic [3:0]      hstop;
    logic [XLEN-1:0] hpc;
    logic            xvld;
    logic [1:0]      xhart;
    logic            xbra;
    logic [XLEN-1:0] xbpc;
    logic            fvld;
    logic [1:0]      fhart;
    logic [XLEN-1:0] fpc;
    logic [3:0]      hrun;
    logic [31:0]     sidle;

    modport master (
        output sena, hstart, hstop, hpc, xvld, xhart, xbra, xbpc,
        input  fvld, fhart, fpc, hrun, sidle
    );

    modport slave (
        input  sena, hstart, hstop, hpc, xvld, xhart, xbra, xbpc,
        output fvld, fhart, fpc, hrun, sidle
    );
endinterface

// File: rtl/t5_hart_sched.sv
// Four-hart barrel scheduler: round-robin issue, per-hart PC file, redirects and start/stop.
// Optional idle-slot counter on sidle is built only when T5_SCHED_IDLE_CNT_EN is defined.
module t5_hart_sched #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic            sclk,
    input logic            srst,
    t5_hart_sched_if.slave bus
);

    logic [XLEN-1:0] pc_q [4];
    logic [3:0]      hrun_q;
    logic [3:0]      busy_q;
    logic [1:0]      ptr_q;
    logic            fvld_q;
    logic [1:0]      fhart_q;
    logic [XLEN-1:0] fpc_q;

    logic [3:0] runnable;
    logic       sel_vld;
    logic [1:0] sel_h;
    logic [1:0] cand;
    logic       retire;
    logic [3:0] issue_oh;
    logic [3:0] clr_oh;
    logic [3:0] busy_n;
    logic [3:0] hrun_n;
    logic [3:0] load;
    logic [XLEN-1:0] hpc_al;
    logic [XLEN-1:0] xbpc_al;

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.hpc[1:0], bus.xbpc[1:0]};

    assign runnable = hrun_q & ~busy_q;
    assign hpc_al   = {bus.hpc[XLEN-1:2], 2'b00};
    assign xbpc_al  = {bus.xbpc[XLEN-1:2], 2'b00};

    // Walk from the farthest candidate back to ptr+1 so the nearest runnable hart wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_h   = ptr_q;
        cand    = ptr_q;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr_q + i[1:0];
            if (runnable[cand]) begin
                sel_vld = 1'b1;
                sel_h   = cand;
            end
        end
    end

    // A retirement on a hart that is not busy is a protocol error and has no effect.
    assign retire = bus.xvld & busy_q[bus.xhart];

    always_comb begin
        issue_oh = '0;
        clr_oh   = '0;
        if (sel_vld) issue_oh[sel_h] = 1'b1;
        if (retire)  clr_oh[bus.xhart] = 1'b1;
    end

    assign busy_n = (busy_q | issue_oh) & ~clr_oh;
    assign load   = bus.hstart & ~hrun_q & ~bus.hstop;
    assign hrun_n = (hrun_q | bus.hstart) & ~bus.hstop;

    always_ff @(posedge sclk) begin
        if (!srst) begin
            for (int h = 0; h < 4; h++) pc_q[h] <= RESET_PC;
            hrun_q  <= 4'b0001;
            busy_q  <= '0;
            ptr_q   <= 2'd3;
            fvld_q  <= 1'b0;
            fhart_q <= '0;
            fpc_q   <= RESET_PC;
        end else if (bus.sena) begin
            if (sel_vld) begin
                fvld_q      <= 1'b1;
                fhart_q     <= sel_h;
                fpc_q       <= pc_q[sel_h];
                pc_q[sel_h] <= pc_q[sel_h] + XLEN'(4);
                ptr_q       <= sel_h;
            end else begin
                fvld_q <= 1'b0;
            end
            busy_q <= busy_n;
            hrun_q <= hrun_n;
            // Later writes win: a redirect overrides the +4, a start load overrides both.
            if (retire && bus.xbra) pc_q[bus.xhart] <= xbpc_al;
            for (int h = 0; h < 4; h++) begin
                if (load[h]) pc_q[h] <= hpc_al;
            end
        end
    end

    assign bus.fvld  = fvld_q;
    assign bus.fhart = fhart_q;
    assign bus.fpc   = fpc_q;
    assign bus.hrun  = hrun_q;

`ifdef T5_SCHED_IDLE_CNT_EN
    logic [31:0] sidle_q;

    // Counts enabled edges that register an empty issue slot; wraps silently.
    always_ff @(posedge sclk) begin
        if (!srst) begin
            sidle_q <= '0;
        end else if (bus.sena && !sel_vld) begin
            sidle_q <= sidle_q + 32'd1;
        end
    end

    assign bus.sidle = sidle_q;
`else
    assign bus.sidle = 32'h0;
`endif

endmodule

// File: tb/tb_t5_hart_sched.sv
// Bench for t5_hart_sched: directed scenarios pinned with literals, then random traffic
// checked every cycle against a behavioural hart model.
module tb_t5_hart_sched;
  localparam int XLEN = 32;

  logic sclk = 1'b0;
  logic srst;
  always #5 sclk = ~sclk;

  t5_hart_sched_if #(.XLEN(XLEN)) bus();

  t5_hart_sched #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .sclk (sclk),
    .srst (srst),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;
  logic [31:0] exp_q[$];

  // ---------------- behavioural model ----------------
  bit [31:0] m_pc[4];
  bit        m_busy[4];
  bit        m_run[4];
  int        m_ptr;
  bit        m_fvld;
  int        m_fhart;
  bit [31:0] m_fpc;
  bit [31:0] m_idle;

  function automatic logic [3:0] m_hrun();
    logic [3:0] r;
    for (int h = 0; h < 4; h++) r[h] = m_run[h];
    return r;
  endfunction

  always @(posedge sclk) begin
    if (!srst) begin
      for (int h = 0; h < 4; h++) begin
        m_pc[h] = 32'h0;
        m_busy[h] = 1'b0;
        m_run[h] = (h == 0);
      end
      m_ptr = 3;
      m_fvld = 1'b0;
      m_fhart = 0;
      m_fpc = 32'h0;
      m_idle = 32'h0;
    end else if (bus.sena) begin
      bit [31:0] npc[4];
      bit        nbusy[4];
      bit        nrun[4];
      int        sel;
      npc = m_pc;
      nbusy = m_busy;
      nrun = m_run;
      sel = -1;
      for (int i = 1; i <= 4; i++) begin
        int h;
        h = (m_ptr + i) % 4;
        if (sel < 0 && m_run[h] && !m_busy[h]) sel = h;
      end
      if (sel >= 0) begin
        m_fvld = 1'b1;
        m_fhart = sel;
        m_fpc = m_pc[sel];
        npc[sel] = m_pc[sel] + 32'd4;
        nbusy[sel] = 1'b1;
        m_ptr = sel;
      end else begin
        m_fvld = 1'b0;
`ifdef T5_SCHED_IDLE_CNT_EN
        m_idle = m_idle + 32'd1;
`endif
      end
      if (bus.xvld && m_busy[bus.xhart]) begin
        nbusy[bus.xhart] = 1'b0;
        if (bus.xbra) npc[bus.xhart] = bus.xbpc & ~32'h3;
      end
      for (int h = 0; h < 4; h++) begin
        if (bus.hstop[h]) nrun[h] = 1'b0;
        else if (bus.hstart[h] && !m_run[h]) begin
          nrun[h] = 1'b1;
          npc[h] = bus.hpc & ~32'h3;
        end
      end
      m_pc = npc;
      m_busy = nbusy;
      m_run = nrun;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge sclk) begin
    if (check_en) begin
      chk("fvld", {31'h0, bus.fvld}, {31'h0, m_fvld});
      chk("fhart", {30'h0, bus.fhart}, 32'(m_fhart));
      chk("fpc", bus.fpc, m_fpc);
      chk("hrun", {28'h0, bus.hrun}, {28'h0, m_hrun()});
      chk("sidle", bus.sidle, m_idle);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hstart = '0;
    bus.hstop = '0;
    bus.hpc = '0;
    bus.xvld = 1'b0;
    bus.xhart = '0;
    bus.xbra = 1'b0;
    bus.xbpc = '0;
  endtask

  int          tbl_h[13];
  logic [31:0] tbl_pc[13];
  int          bl[$];

  initial begin
    tbl_h = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    tbl_pc = '{32'h100, 32'h100, 32'h8, 32'h104, 32'h104, 32'h104, 32'hC,
               32'h108, 32'h2000, 32'h108, 32'h10, 32'h10C, 32'h2004};

    srst = 1'b0;
    bus.sena = 1'b0;
    idle_inputs();
    tick();
    tick();
    check_en = 1'b1;

    chk("rst_fvld", {31'h0, bus.fvld}, 32'h0);
    chk("rst_fpc", bus.fpc, 32'h0);
    chk("rst_hrun", {28'h0, bus.hrun}, 32'h1);
    chk("rst_sidle", bus.sidle, 32'h0);
    srst = 1'b1;

    // Hart 0 alone, retired between issues.
    bus.sena = 1'b1;
    tick();
    chk("h0_first_fvld", {31'h0, bus.fvld}, 32'h1);
    chk("h0_first_pc", bus.fpc, 32'h0);
    bus.xvld = 1'b1;
    bus.xhart = 2'd0;
    tick();
    chk("h0_gap_fvld", {31'h0, bus.fvld}, 32'h0);
`ifdef T5_SCHED_IDLE_CNT_EN
    chk("h0_gap_sidle", bus.sidle, 32'h1);
`endif
    bus.xvld = 1'b0;
    tick();
    chk("h0_second_pc", bus.fpc, 32'h4);

    // Start harts 1..3 at 0x100, then walk the round robin with prompt retirements.
    bus.hstart = 4'b1110;
    bus.hpc = 32'h100;
    bus.xvld = 1'b1;
    bus.xhart = 2'd0;
    tick();
    bus.hstart = '0;
    bus.xvld = 1'b0;
    tick();
    chk("start_hart", {30'h0, bus.fhart}, 32'h1);
    chk("start_pc", bus.fpc, 32'h100);
    chk("start_hrun", {28'h0, bus.hrun}, 32'hF);

    for (int k = 0; k < 13; k++) exp_q.push_back(tbl_pc[k]);
    for (int k = 0; k < 13; k++) begin
      logic [31:0] e;
      bus.xvld = 1'b1;
      bus.xhart = 2'(m_fhart);
      bus.xbra = (k == 5);
      bus.xbpc = (k == 5) ? 32'h2003 : $urandom;
      tick();
      e = exp_q.pop_front();
      chk("rr_hart", {30'h0, bus.fhart}, 32'(tbl_h[k]));
      chk("rr_pc", bus.fpc, e);
    end
    bus.xbra = 1'b0;

    // Freeze with retirement pulses present; nothing may move.
    bus.sena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.xvld = 1'b1;
      bus.xhart = 2'd2;
      bus.xbra = 1'b1;
      bus.xbpc = 32'h9000;
      tick();
      chk("frz_hart", {30'h0, bus.fhart}, 32'h2);
      chk("frz_pc", bus.fpc, 32'h2004);
    end
    bus.sena = 1'b1;
    bus.xbra = 1'b0;
    tick();
    chk("resume_hart", {30'h0, bus.fhart}, 32'h3);
    chk("resume_pc", bus.fpc, 32'h10C);

    // Stop everything: the edge still issues once from the old run state.
    bus.hstop = 4'hF;
    bus.xvld = 1'b1;
    bus.xhart = 2'd3;
    tick();
    chk("stop_hrun", {28'h0, bus.hrun}, 32'h0);
    chk("stop_last_hart", {30'h0, bus.fhart}, 32'h0);
    chk("stop_last_pc", bus.fpc, 32'h14);
    bus.hstop = '0;
    bus.xhart = 2'd0;
    tick();
    chk("allstop_fvld", {31'h0, bus.fvld}, 32'h0);
    chk("allstop_pc_hold", bus.fpc, 32'h14);
    bus.xvld = 1'b0;
    bus.hstart = 4'b0010;
    bus.hstop = 4'b0010;
    bus.hpc = 32'h700;
    tick();
    chk("startstop_hrun", {28'h0, bus.hrun}, 32'h0);
    idle_inputs();
    tick();
    chk("allstop_fvld2", {31'h0, bus.fvld}, 32'h0);

    // Random traffic, retiring only harts the model holds busy.
    for (int n = 0; n < 3000; n++) begin
      bus.sena = ($urandom_range(0, 7) != 0);
      bus.hstart = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      bus.hstop = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      bus.hpc = $urandom;
      bus.xbpc = $urandom;
      bus.xbra = ($urandom_range(0, 2) == 0);
      bl.delete();
      for (int h = 0; h < 4; h++) if (m_busy[h]) bl.push_back(h);
      if (bl.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.xvld = 1'b1;
        bus.xhart = 2'(bl[$urandom_range(0, bl.size() - 1)]);
        bus.hstart[bus.xhart] = 1'b0;
      end else begin
        bus.xvld = 1'b0;
        bus.xhart = 2'($urandom);
      end
      srst = ($urandom_range(0, 499) != 0);
      tick();
    end

    srst = 1'b1;
    idle_inputs();
    tick();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
